// File: rtl/button_debouncer_if.sv
// Button conditioning bundle: raw button in, debounced level and strobes out.
// The debouncer connects through the slave modport; its driver uses master.
interface button_debouncer_if;
  logic btn_in;
  logic level;
  logic press;
  logic released;

  modport master (output btn_in, input level, press, released);
  modport slave  (input btn_in, output level, press, released);
endinterface

// File: rtl/button_debouncer.sv
// Synchronises, debounces and edge-detects a raw push-button, producing press
// strobes (with optional auto-repeat) and release strobes in the clk domain.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic               clk,
  input  logic               rst,
  button_debouncer_if.slave  bus
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HCNT_SAT    = HW'(HMAX);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;

  logic          s1_reg, sync_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, level_next;
  state_t        state_reg, state_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic          press_reg, press_next;
  logic          released_reg, released_next;

  logic differ, accept, rise, fall, delay_due, period_due;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples; any matching sample restarts the count.
  always_comb begin
    differ     = (sync_reg != level_reg);
    accept     = differ && (cnt_reg == CNT_LAST);
    rise       = accept && !level_reg;
    fall       = accept && level_reg;
    cnt_next   = (!differ || accept) ? '0 : cnt_reg + 1'b1;
    level_next = accept ? ~level_reg : level_reg;
    delay_due  = (REPEAT_DELAY != 0) && (hcnt_reg == DELAY_LAST);
    period_due = (hcnt_reg == PERIOD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg       <= 1'b0;
      sync_reg     <= 1'b0;
      cnt_reg      <= '0;
      level_reg    <= 1'b0;
      state_reg    <= ST_IDLE;
      hcnt_reg     <= '0;
      press_reg    <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      s1_reg       <= bus.btn_in;
      sync_reg     <= s1_reg;
      cnt_reg      <= cnt_next;
      level_reg    <= level_next;
      state_reg    <= state_next;
      hcnt_reg     <= hcnt_next;
      press_reg    <= press_next;
      released_reg <= released_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (rise) state_next = ST_HELD;
      ST_HELD: begin
        if (fall)           state_next = ST_IDLE;
        else if (delay_due) state_next = ST_REPEAT;
      end
      ST_REPEAT: if (fall) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A falling level always wins over a repeat that falls due on the same edge.
  always_comb begin
    press_next    = 1'b0;
    released_next = 1'b0;
    hcnt_next     = hcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        hcnt_next  = '0;
        press_next = rise;
      end
      ST_HELD, ST_REPEAT: begin
        if (fall) begin
          released_next = 1'b1;
          hcnt_next     = '0;
        end else if ((state_reg == ST_HELD) ? delay_due : period_due) begin
          press_next = 1'b1;
          hcnt_next  = '0;
        end else if (hcnt_reg != HCNT_SAT) begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      default: hcnt_next = '0;
    endcase
  end

  assign bus.level    = level_reg;
  assign bus.press    = press_reg;
  assign bus.released = released_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: three parameterisations share one button; an
// event-level model is compared every cycle, plus directed literal checks.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst, btn, ctr_clr;
  logic btn_s, rst_s;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  button_debouncer_if ia ();
  button_debouncer_if ib ();
  button_debouncer_if ic ();
  assign ia.btn_in = btn;
  assign ib.btn_in = btn;
  assign ic.btn_in = btn;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  button_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  button_debouncer #(.DEBOUNCE_CYCLES(1), .REPEAT_DELAY(3), .REPEAT_PERIOD(1))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  // Downstream modulo-7 counter fed by dut_a's press strobe.
  logic [2:0] ctr;
  logic       wrap_seen;
  always @(posedge clk) begin
    if (rst || ctr_clr) begin
      ctr <= 3'd0;
      wrap_seen <= 1'b0;
    end else if (ia.press) begin
      if (ctr == 3'd6) begin
        ctr <= 3'd0;
        wrap_seen <= 1'b1;
      end else begin
        ctr <= ctr + 3'd1;
      end
    end
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    btn_s <= btn;
    rst_s <= rst;
  end

  // Model: level flips once the synchronised value has held the opposite
  // value for d edges; repeats land at RD + m*RP edges after the press.
  typedef struct {
    logic s1, sync, last, level, press, rel;
    int run, hold;
  } model_t;

  function automatic model_t step(model_t m, logic b, logic r, int d, int rd, int rp);
    model_t n = m;
    if (r) begin
      n.s1 = 0; n.sync = 0; n.last = 0; n.level = 0; n.press = 0; n.rel = 0;
      n.run = 0; n.hold = 0;
      return n;
    end
    if (m.sync == m.last) n.run = m.run + 1;
    else begin
      n.run  = 1;
      n.last = m.sync;
    end
    n.press = 0;
    n.rel   = 0;
    if (m.sync != m.level && n.run >= d) begin
      n.level = m.sync;
      n.press = m.sync;
      n.rel   = !m.sync;
      n.hold  = 0;
    end else if (m.level) begin
      n.hold = m.hold + 1;
      if (rd > 0 && n.hold >= rd && (n.hold - rd) % rp == 0) n.press = 1;
    end
    n.sync = m.s1;
    n.s1   = b;
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, act, exp);
    end
  endtask

  model_t ma, mb, mc;
  int pa[$], ra[$], pb[$], rb[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      ma = step(ma, btn_s, rst_s, 4, 20, 8);
      mb = step(mb, btn_s, rst_s, 4, 0, 1);
      mc = step(mc, btn_s, rst_s, 1, 3, 1);
      cmp("a_level", ia.level, ma.level);
      cmp("a_press", ia.press, ma.press);
      cmp("a_release", ia.released, ma.rel);
      cmp("b_level", ib.level, mb.level);
      cmp("b_press", ib.press, mb.press);
      cmp("b_release", ib.released, mb.rel);
      cmp("c_level", ic.level, mc.level);
      cmp("c_press", ic.press, mc.press);
      cmp("c_release", ic.released, mc.rel);
      if (ia.press)    pa.push_back(cyc);
      if (ia.released) ra.push_back(cyc);
      if (ib.press)    pb.push_back(cyc);
      if (ib.released) rb.push_back(cyc);
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    pa.delete(); ra.delete(); pb.delete(); rb.delete();
  endtask

  int t, p, e, f, r;
  int rep_off[6] = '{0, 20, 28, 36, 44, 52};

  initial begin
    rst = 1'b1; btn = 1'b1; ctr_clr = 1'b0;
    go(2);
    chk("rst_level", int'(ia.level), 0);
    chk("rst_press", int'(ia.press), 0);
    chk("rst_release", int'(ia.released), 0);
    go(1);
    rst = 1'b0;
    t = cyc;
    p = t + 6;
    // Hold through auto-repeat, then let go so the fall coincides with a due repeat.
    go(p + 54 - cyc);
    btn = 1'b0;
    go(20);
    chk("rep_a_count", pa.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < pa.size()) chk($sformatf("rep_a_%0d", i), pa[i] - p, rep_off[i]);
    chk("rel_a_count", ra.size(), 1);
    if (ra.size() > 0) chk("rel_a_time", ra[0], p + 60);
    chk("rep_b_count", pb.size(), 1);
    if (pb.size() > 0) chk("press_b_time", pb[0], p);
    chk("rel_b_count", rb.size(), 1);

    clear_q();
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      go(2);
    end
    btn = 1'b0;
    go(10);
    chk("bounce_a_press", pa.size(), 0);
    chk("bounce_a_release", ra.size(), 0);
    chk("bounce_b_press", pb.size(), 0);
    chk("bounce_b_release", rb.size(), 0);

    clear_q();
    btn = 1'b1;
    go(3);
    btn = 1'b0;
    go(10);
    chk("pulse3_a_press", pa.size(), 0);
    chk("pulse3_b_press", pb.size(), 0);

    clear_q();
    btn = 1'b1;
    e = cyc + 1;
    go(100);
    btn = 1'b0;
    f = cyc + 1;
    go(10);
    chk("clean_a_first", (pa.size() > 0) ? pa[0] : -1, e + 5);
    chk("hold100_a_count", pa.size(), 11);
    chk("hold100_a_rel", (ra.size() > 0) ? ra[0] : -1, f + 5);
    chk("norep_b_press", pb.size(), 1);
    chk("norep_b_time", (pb.size() > 0) ? pb[0] : -1, e + 5);
    chk("norep_b_rel", rb.size(), 1);
    chk("norep_b_reltime", (rb.size() > 0) ? rb[0] : -1, f + 5);

    clear_q();
    btn = 1'b1;
    e = cyc + 1;
    go(20);
    rst = 1'b1;
    go(2);
    rst = 1'b0;
    r = cyc;
    go(15);
    chk("midrst_no_release", ra.size(), 0);
    chk("midrst_press_count", pa.size(), 2);
    if (pa.size() > 1) begin
      chk("midrst_first", pa[0], e + 5);
      chk("midrst_fresh", pa[1], r + 6);
    end
    btn = 1'b0;
    go(10);

    ctr_clr = 1'b1;
    go(1);
    ctr_clr = 1'b0;
    clear_q();
    for (int i = 0; i < 9; i++) begin
      btn = 1'b1;
      go(10);
      btn = 1'b0;
      go(10);
    end
    chk("int_press_count", pa.size(), 9);
    chk("int_counter", int'(ctr), 2);
    chk("int_wrap", int'(wrap_seen), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw mechanical push-button into clean single-cycle strobes for the modulo-N counter, which takes this block's `press` output on its `ce` input. The raw input is synchronised, debounced and edge-detected. Holding the button optionally produces auto-repeat strobes. The block sits directly upstream of the counter, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required to accept a new level; ≥1.
- `REPEAT_DELAY`, default 0: cycles from the accepted press to the first repeat strobe; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 1: cycles between subsequent repeat strobes; ≥1; ignored when `REPEAT_DELAY` = 0.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw button, asynchronous to `clk`, active-high.
- `level`  output  1  debounced button state.
- `press`  output  1  one-cycle strobe on an accepted press and on each repeat; drives counter `ce`.
- `release`  output  1  one-cycle strobe on an accepted release.

## Operation
- Synchroniser: two flops, `btn_in` → `s1` → `btn_sync`. Both reset to 0.
- Stability counter `cnt`: width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `btn_sync` == `level`, `cnt` clears to 0.
  - Otherwise `cnt` increments.
  - If `btn_sync` != `level` and `cnt` == `DEBOUNCE_CYCLES-1`, then on that edge `level` toggles and `cnt` clears.
  - Any sample that matches `level` restarts the count, so bounce shorter than `DEBOUNCE_CYCLES` is fully rejected.
- FSM states:
  - IDLE: `level` = 0.
  - HELD: `level` = 1, first repeat not yet issued.
  - REPEAT: `level` = 1, periodic repeats.
- FSM transitions:
  - IDLE → HELD when `level` rises. `press` = 1 for that cycle and hold counter `hcnt` clears.
  - HELD → REPEAT when `REPEAT_DELAY` ≠ 0 and `hcnt` == `REPEAT_DELAY-1`. `press` = 1 and `hcnt` clears.
  - REPEAT → REPEAT when `hcnt` == `REPEAT_PERIOD-1`. `press` = 1 and `hcnt` clears.
  - HELD or REPEAT → IDLE when `level` falls. `release` = 1, `hcnt` clears, and no `press` fires that cycle even if a repeat was due.
- `hcnt` width: `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`. It increments only in HELD/REPEAT and never wraps past its terminal value.
- `press` and `release` are registered outputs. They are never high together and never high for two consecutive cycles, except that with `REPEAT_PERIOD` = 1 in REPEAT, `press` is held continuously.

## Timing
- Reset: `s1`, `btn_sync`, `cnt`, `hcnt`, `level`, `press` and `release` are all 0; state is IDLE. Reset overrides every other event on the same edge.
- Press latency: if `btn_in` goes to 1 before edge k and stays there, `level` and `press` are high in the cycle after edge k+1+`DEBOUNCE_CYCLES`. With D=4 that is after edge k+5.
- Release latency is identical, measured on `level`/`release`.
- First repeat: `REPEAT_DELAY` cycles after the press strobe. Each following repeat: `REPEAT_PERIOD` cycles after the previous strobe.
- `rst` asserted mid-hold: the block returns to IDLE with no `release` strobe. If the button is still held after `rst` drops, a fresh `press` fires `2+DEBOUNCE_CYCLES` cycles later, because the synchroniser restarts from 0.
- `DEBOUNCE_CYCLES` = 1: `level` follows `btn_sync` with one cycle of delay.

## Test plan
Unless stated otherwise, the bench uses D=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: hold `rst` for 3 cycles while `btn_in` = 1 → all outputs stay 0 during reset. `press` then fires exactly 6 cycles after `rst` drops.
- Clean press: step `btn_in` 0→1 before edge 10 → `press` high only in the cycle after edge 15. `level` = 1 from then on and `release` stays 0.
- Bounce rejection:
  - Toggle `btn_in` every 2 cycles for 40 cycles → `level`, `press` and `release` stay 0 throughout.
  - Pulse `btn_in` high for exactly 3 cycles → no `press`.
- Auto-repeat: hold the button for 60 cycles after the first `press` at cycle P → `press` strobes at P, P+20, P+28, P+36, P+44, P+52. After release, `release` fires once, 6 cycles after `btn_in` falls, and there is no trailing `press`.
- Repeat disabled: with REPEAT_DELAY=0, hold for 100 cycles → exactly one `press` and one `release`.
- Integration: the block drives the counter's `ce` with MODULO=7 and 9 clean presses → counter output reads 2 (wrap from 6 to 0 observed).
